data_memory_ctrl: RTL and testbench

Parametrised, byte-addressable data memory for the multi-cycle CPU, replacing the fixed word-only data memory. It serves one load or store at a time through a level request / single-cycle `Ready` handshake, with a configurable number of wait states. It supports byte, half-word and word accesses with sign or zero extension on loads. Misaligned, out-of-range and malformed requests are reported on `AddrErr` instead of corrupting memory. It sits between the CPU's MEM-stage control and the datapath's memory-data register.

---
 rtl/data_memory_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_memory_ctrl : byte-addressable big-endian data memory with wait states
// Revision 1.0
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic [31:0]       writeData,
  output logic [31:0]       readData,
  output logic              Ready,
  output logic              AddrErr
);

  localparam int IDX_W     = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int WAIT_LOAD = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              addr_err_q, addr_err_d;

  logic [7:0] mem_q [DEPTH_BYTES] = '{default: 8'h00};

  logic              in_idle;
  logic              accept;
  logic              resp_entry;
  logic [ADDR_W-1:0] eff_addr;
  logic [31:0]       eff_wdata;
  logic [1:0]        eff_size;
  logic              eff_uns;
  logic              eff_rd;
  logic              eff_wr;
  logic [2:0]        nbytes;
  logic [ADDR_W:0]   end_addr;
  logic              err;
  logic              mem_we;
  logic [IDX_W-1:0]  idx0, idx1, idx2, idx3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       load_val;

  // With zero wait states the response edge is also the accept edge, so the
  // access must be evaluated from the live inputs rather than the latches.
  assign in_idle   = (state_q == S_IDLE);
  assign accept    = in_idle && (MemRead || MemWrite);
  assign eff_addr  = in_idle ? DataAddr  : addr_q;
  assign eff_wdata = in_idle ? writeData : wdata_q;
  assign eff_size  = in_idle ? Size      : size_q;
  assign eff_uns   = in_idle ? Unsigned  : uns_q;
  assign eff_rd    = in_idle ? MemRead   : rd_q;
  assign eff_wr    = in_idle ? MemWrite  : wr_q;

  always_comb begin
    nbytes = 3'd4;
    case (eff_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  assign end_addr = {1'b0, eff_addr} + {{(ADDR_W-2){1'b0}}, nbytes};

  assign err = (eff_rd && eff_wr)
            || (eff_size == 2'b11)
            || ((eff_size == 2'b01) && eff_addr[0])
            || ((eff_size == 2'b10) && (eff_addr[1:0] != 2'b00))
            || (end_addr > (ADDR_W+1)'(DEPTH_BYTES));

  assign idx0 = eff_addr[IDX_W-1:0];
  assign idx1 = idx0 + IDX_W'(1);
  assign idx2 = idx0 + IDX_W'(2);
  assign idx3 = idx0 + IDX_W'(3);
  assign b0   = mem_q[idx0];
  assign b1   = mem_q[idx1];
  assign b2   = mem_q[idx2];
  assign b3   = mem_q[idx3];

  always_comb begin
    load_val = {b0, b1, b2, b3};
    case (eff_size)
      2'b00:   load_val = {{24{~eff_uns & b0[7]}}, b0};
      2'b01:   load_val = {{16{~eff_uns & b0[7]}}, b0, b1};
      default: load_val = {b0, b1, b2, b3};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = DataAddr;
          wdata_d = writeData;
          size_d  = Size;
          uns_d   = Unsigned;
          rd_d    = MemRead;
          wr_d    = MemWrite;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_LOAD);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_entry = (state_d == S_RESP) && (state_q != S_RESP);
  assign mem_we     = resp_entry && eff_wr && !err && !Reset;

  always_comb begin
    read_data_d = read_data_q;
    addr_err_d  = 1'b0;
    if (resp_entry) begin
      addr_err_d = err;
      if (err) begin
        read_data_d = 32'h0;
      end else if (eff_rd) begin
        read_data_d = load_val;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      read_data_q <= 32'h0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      read_data_q <= read_data_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Memory is deliberately outside the reset domain: contents survive Reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      case (eff_size)
        2'b00: mem_q[idx0] <= eff_wdata[7:0];
        2'b01: begin
          mem_q[idx0] <= eff_wdata[15:8];
          mem_q[idx1] <= eff_wdata[7:0];
        end
        default: begin
          mem_q[idx0] <= eff_wdata[31:24];
          mem_q[idx1] <= eff_wdata[23:16];
          mem_q[idx2] <= eff_wdata[15:8];
          mem_q[idx3] <= eff_wdata[7:0];
        end
      endcase
    end
  end

  assign readData = read_data_q;
  assign Ready    = (state_q == S_RESP);
  assign AddrErr  = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// tb_data_memory_ctrl : directed self-checking bench for data_memory_ctrl
// (default instance with one wait state, second instance with none).
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        mem_read = 1'b0, mem_write = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] read_data;
  logic        ready, addr_err;

  logic        mem_read0 = 1'b0, mem_write0 = 1'b0, uns0 = 1'b0;
  logic [1:0]  size0 = 2'b00;
  logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
  logic [31:0] read_data0;
  logic        ready0, addr_err0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] r_data;
  logic        r_err;
  logic [2:0]  r_pat;

  always #5 clk = ~clk;

  data_memory_ctrl dut (
    .CLK(clk), .Reset(rst), .MemRead(mem_read), .MemWrite(mem_write),
    .Size(size), .Unsigned(uns), .DataAddr(addr), .writeData(wdata),
    .readData(read_data), .Ready(ready), .AddrErr(addr_err)
  );

  data_memory_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .Reset(rst), .MemRead(mem_read0), .MemWrite(mem_write0),
    .Size(size0), .Unsigned(uns0), .DataAddr(addr0), .writeData(wdata0),
    .readData(read_data0), .Ready(ready0), .AddrErr(addr_err0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response cycle.
  // pat = {Ready 1, 2, 3 cycles after accept}; data/err sampled in cycle 2.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic un, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] data, output logic err, output logic [2:0] pat);
    mem_read = rd; mem_write = wr; size = sz; uns = un; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0;
    data = 32'h0; err = 1'b0; pat = 3'b000;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      pat[3-i] = ready;
      if (i == 2) begin
        data = read_data;
        err  = addr_err;
      end
    end
  endtask

  task automatic load_ok(input string tag, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] exp);
    access(1'b1, 1'b0, sz, un, a, 32'h0, r_data, r_err, r_pat);
    check({tag, " data"}, r_data, exp);
    check({tag, " err"}, {31'b0, r_err}, 32'h0);
  endtask

  task automatic expect_err(input string tag, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic [31:0] a);
    access(rd, wr, sz, 1'b0, a, 32'hA5A5_A5A5, r_data, r_err, r_pat);
    check({tag, " err"}, {31'b0, r_err}, 32'h1);
    check({tag, " data"}, r_data, 32'h0);
    check({tag, " ready"}, {29'b0, r_pat}, 32'h2);
  endtask

  // Zero-wait instance: request held to the accept edge, dropped in RESP.
  task automatic access0(input string tag, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic un, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp, input logic chk_data);
    mem_read0 = rd; mem_write0 = wr; size0 = sz; uns0 = un; addr0 = a; wdata0 = wd;
    @(posedge clk);
    @(negedge clk);
    check({tag, " ready"}, {31'b0, ready0}, 32'h1);
    check({tag, " err"}, {31'b0, addr_err0}, 32'h0);
    if (chk_data) check({tag, " data"}, read_data0, exp);
    mem_read0 = 1'b0; mem_write0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " idle"}, {31'b0, ready0}, 32'h0);
  endtask

  initial begin
    #12;
    check("reset ready", {31'b0, ready}, 32'h0);
    check("reset err", {31'b0, addr_err}, 32'h0);
    check("reset data", read_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Word round trip
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'd8, 32'h1234_5678, r_data, r_err, r_pat);
    check("sw8 ready", {29'b0, r_pat}, 32'h2);
    check("sw8 err", {31'b0, r_err}, 32'h0);
    check("sw8 data held", r_data, 32'h0);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, r_data, r_err, r_pat);
    check("lw8 ready", {29'b0, r_pat}, 32'h2);
    check("lw8 data", r_data, 32'h1234_5678);
    check("lw8 err", {31'b0, r_err}, 32'h0);

    // Byte access
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'd9, 32'hFFFF_FFAB, r_data, r_err, r_pat);
    check("sb9 data held", r_data, 32'h1234_5678);
    load_ok("lw8 after sb", 2'b10, 1'b0, 32'd8, 32'h12AB_5678);
    load_ok("lb9", 2'b00, 1'b0, 32'd9, 32'hFFFF_FFAB);
    load_ok("lbu9", 2'b00, 1'b1, 32'd9, 32'h0000_00AB);

    // Half-word access
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'd12, 32'h0000_8001, r_data, r_err, r_pat);
    check("sh12 err", {31'b0, r_err}, 32'h0);
    load_ok("lh12", 2'b01, 1'b0, 32'd12, 32'hFFFF_8001);
    load_ok("lhu12", 2'b01, 1'b1, 32'd12, 32'h0000_8001);
    load_ok("lb13", 2'b00, 1'b0, 32'd13, 32'h0000_0001);
    load_ok("lwu8", 2'b10, 1'b1, 32'd8, 32'h12AB_5678);

    // Error cases, each preceded by a good load so readData is non-zero
    expect_err("lw10", 1'b1, 1'b0, 2'b10, 32'd10);
    load_ok("pre1", 2'b10, 1'b0, 32'd8, 32'h12AB_5678);
    expect_err("sw126", 1'b0, 1'b1, 2'b10, 32'd126);
    load_ok("pre2", 2'b10, 1'b0, 32'd8, 32'h12AB_5678);
    expect_err("lb128", 1'b1, 1'b0, 2'b00, 32'd128);
    load_ok("pre3", 2'b10, 1'b0, 32'd8, 32'h12AB_5678);
    expect_err("size11", 1'b1, 1'b0, 2'b11, 32'd8);
    load_ok("pre4", 2'b10, 1'b0, 32'd8, 32'h12AB_5678);
    expect_err("rdwr", 1'b1, 1'b1, 2'b10, 32'd8);
    load_ok("lw8 after rdwr", 2'b10, 1'b0, 32'd8, 32'h12AB_5678);
    load_ok("lw124", 2'b10, 1'b0, 32'd124, 32'h0);
    load_ok("lh126", 2'b01, 1'b0, 32'd126, 32'h0);

    // Reset during WAIT drops the pending store
    load_ok("pre rst", 2'b10, 1'b0, 32'd12, 32'h8001_0000);
    mem_write = 1'b1; size = 2'b10; addr = 32'd16; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst ready", {31'b0, ready}, 32'h0);
    check("rst err", {31'b0, addr_err}, 32'h0);
    check("rst data", read_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    load_ok("lw16 after rst", 2'b10, 1'b0, 32'd16, 32'h0);
    load_ok("lw8 survives rst", 2'b10, 1'b0, 32'd8, 32'h12AB_5678);

    // Zero wait states: one access every two cycles
    access0("z sw4", 1'b0, 1'b1, 2'b10, 1'b0, 32'd4, 32'hCAFE_F00D, 32'h0, 1'b0);
    access0("z lw4", 1'b1, 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'hCAFE_F00D, 1'b1);
    access0("z lhu6", 1'b1, 1'b0, 2'b01, 1'b1, 32'd6, 32'h0, 32'h0000_F00D, 1'b1);
    access0("z lb4", 1'b1, 1'b0, 2'b00, 1'b0, 32'd4, 32'h0, 32'hFFFF_FFCA, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
